// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker
//
// Sits between fetch/execute and the 2-bit saturating branch predictor.
// Every accepted branch asks the predictor for a prediction and queues it
// in an in-order FIFO. Each accepted outcome pops the oldest prediction,
// trains the predictor with the real outcome and flags a misprediction.
//
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   br_valid        in   fetch presents a branch
//   br_ready        out  branch accepted on br_valid && br_ready
//   res_valid       in   execute presents the oldest branch's outcome
//   res_taken       in   actual outcome (1 = taken)
//   res_ready       out  outcome accepted on res_valid && res_ready
//   pred_request    out  predictor request pulse
//   pred_result     out  predictor training pulse
//   pred_taken      out  training outcome, held between pulses
//   pred_prediction in   prediction returned by the predictor
//   head_pred       out  stored prediction of the oldest branch, 0 when empty
//   mispredict      out  one-cycle pulse on a resolved misprediction
//   occupancy       out  outstanding branches
//   branch_cnt      out  resolved branches, saturating
//   mispredict_cnt  out  mispredictions, saturating
//
// state   | meaning
// IDLE    | accepts branches and outcomes
// REQ     | pred_request pulse is on the wire to the predictor
// CAPTURE | predictor output is sampled and pushed at the next edge

module branch_outcome_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     br_valid,
    output logic                     br_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_ready,
    output logic                     pred_request,
    output logic                     pred_result,
    output logic                     pred_taken,
    input  logic                     pred_prediction,
    output logic                     head_pred,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispredict_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] fifo;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             br_acc;
    logic             res_acc;
    logic             head_bit;
    logic             is_mispredict;

    // An outcome always wins over a new branch in the same cycle, so the
    // two handshakes are mutually exclusive and push/pop never collide.
    assign br_ready  = (state == IDLE) && (count < FULL_CNT) && !res_valid;
    assign res_ready = (state == IDLE) && (count != '0);
    assign br_acc    = br_valid && br_ready;
    assign res_acc   = res_valid && res_ready;

    assign head_bit      = fifo[rd_ptr];
    assign head_pred     = (count != '0) ? head_bit : 1'b0;
    assign is_mispredict = (head_bit != res_taken);
    assign occupancy     = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fifo           <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pred_request   <= 1'b0;
            pred_result    <= 1'b0;
            pred_taken     <= 1'b0;
            mispredict     <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            pred_request <= 1'b0;
            pred_result  <= 1'b0;
            mispredict   <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_acc) begin
                        pred_result <= 1'b1;
                        pred_taken  <= res_taken;
                        mispredict  <= is_mispredict;
                        rd_ptr      <= rd_ptr + 1'b1;
                        count       <= count - 1'b1;
                        if (branch_cnt != '1) begin
                            branch_cnt <= branch_cnt + 1'b1;
                        end
                        if (is_mispredict && (mispredict_cnt != '1)) begin
                            mispredict_cnt <= mispredict_cnt + 1'b1;
                        end
                    end else if (br_acc) begin
                        pred_request <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    fifo[wr_ptr] <= pred_prediction;
                    wr_ptr       <= wr_ptr + 1'b1;
                    count        <= count + 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Bench for branch_outcome_tracker: a behavioural 2-bit predictor drives
// pred_prediction, a reference model tracks the outstanding-branch queue,
// and a monitor pops expected predictor pulses from scoreboard queues.
module tb_branch_outcome_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             br_valid = 1'b0;
    logic             res_valid = 1'b0;
    logic             res_taken = 1'b0;
    logic             br_ready;
    logic             res_ready;
    logic             pred_request;
    logic             pred_result;
    logic             pred_taken;
    logic             pred_prediction;
    logic             head_pred;
    logic             mispredict;
    logic [OW-1:0]    occupancy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_outcome_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .pred_request(pred_request), .pred_result(pred_result),
        .pred_taken(pred_taken), .pred_prediction(pred_prediction),
        .head_pred(head_pred), .mispredict(mispredict),
        .occupancy(occupancy), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    // Environment: the predictor itself, trained only by the DUT's pulses
    // and never reset by this block.
    logic [1:0] env_ctr = 2'b00;
    always @(posedge clk) begin
        if (pred_result) begin
            if (pred_taken && env_ctr != 2'd3) env_ctr <= env_ctr + 2'd1;
            else if (!pred_taken && env_ctr != 2'd0) env_ctr <= env_ctr - 2'd1;
        end
    end
    assign pred_prediction = env_ctr[1];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        bit taken;
        bit mis;
        int bcnt;
        int mcnt;
    } res_exp_t;

    bit       mq[$];
    res_exp_t rq[$];
    bit       reqq[$];
    int       busy = 0;
    bit       pend_pred = 1'b0;
    int       mdl_ctr = 0;
    int       m_bcnt = 0;
    int       m_mcnt = 0;
    bit       last_res_acc = 1'b0;
    int       sat_max = (1 << CNT_W) - 1;

    // Monitor
    res_exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_res_exclusive", 32'(pred_request && pred_result), 32'd0);
            check("pred_request", 32'(pred_request), 32'(reqq.size() > 0));
            if (reqq.size() > 0) void'(reqq.pop_front());
            check("pred_result", 32'(pred_result), 32'(rq.size() > 0));
            if (rq.size() > 0) begin
                mon_e = rq.pop_front();
                check("pred_taken", 32'(pred_taken), 32'(mon_e.taken));
                check("mispredict", 32'(mispredict), 32'(mon_e.mis));
                check("branch_cnt", 32'(branch_cnt), 32'(mon_e.bcnt));
                check("mispredict_cnt", 32'(mispredict_cnt), 32'(mon_e.mcnt));
            end else begin
                check("mispredict_quiet", 32'(mispredict), 32'd0);
            end
        end
    end

    task automatic cycle(input bit bv, input bit rv, input bit rt);
        bit idle, e_br, e_rr, b_acc, r_acc, h, mis;
        @(negedge clk);
        br_valid  = bv;
        res_valid = rv;
        res_taken = rt;
        #1;
        idle = (busy == 0);
        e_br = idle && (mq.size() < DEPTH) && !rv;
        e_rr = idle && (mq.size() > 0);
        check("br_ready", 32'(br_ready), 32'(e_br));
        check("res_ready", 32'(res_ready), 32'(e_rr));
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("head_pred", 32'(head_pred), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        b_acc = bv && e_br;
        r_acc = rv && e_rr;
        @(posedge clk);
        last_res_acc = r_acc;
        if (busy > 0) begin
            busy--;
            if (busy == 0) mq.push_back(pend_pred);
        end
        if (r_acc) begin
            h   = mq.pop_front();
            mis = (h != rt);
            if (m_bcnt < sat_max) m_bcnt++;
            if (mis && m_mcnt < sat_max) m_mcnt++;
            rq.push_back('{rt, mis, m_bcnt, m_mcnt});
            mdl_ctr = rt ? ((mdl_ctr < 3) ? mdl_ctr + 1 : 3) : ((mdl_ctr > 0) ? mdl_ctr - 1 : 0);
        end
        if (b_acc) begin
            busy      = 2;
            pend_pred = (mdl_ctr >= 2);
            reqq.push_back(1'b1);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mq.delete();
        rq.delete();
        reqq.delete();
        busy   = 0;
        m_bcnt = 0;
        m_mcnt = 0;
        repeat (n) begin
            @(negedge clk);
            br_valid  = 1'($urandom);
            res_valid = 1'($urandom);
            res_taken = 1'($urandom);
            #1;
            check("rst_br_ready", 32'(br_ready), 32'(!res_valid));
            check("rst_res_ready", 32'(res_ready), 32'd0);
            check("rst_pred_request", 32'(pred_request), 32'd0);
            check("rst_pred_result", 32'(pred_result), 32'd0);
            check("rst_pred_taken", 32'(pred_taken), 32'd0);
            check("rst_mispredict", 32'(mispredict), 32'd0);
            check("rst_head_pred", 32'(head_pred), 32'd0);
            check("rst_occupancy", 32'(occupancy), 32'd0);
            check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
            check("rst_mispredict_cnt", 32'(mispredict_cnt), 32'd0);
        end
        @(negedge clk);
        br_valid  = 1'b0;
        res_valid = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(3);

        // Cold mispredict: predictor starts strongly not-taken
        cycle(1'b1, 1'b0, 1'b0);
        #1 check("cold_request_pulse", 32'(pred_request), 32'd1);
        idle_cycles(2);
        #1 check("cold_head", 32'(head_pred), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        #1;
        check("cold_pred_result", 32'(pred_result), 32'd1);
        check("cold_pred_taken", 32'(pred_taken), 32'd1);
        check("cold_mispredict", 32'(mispredict), 32'd1);
        check("cold_branch_cnt", 32'(branch_cnt), 32'd1);
        check("cold_mispredict_cnt", 32'(mispredict_cnt), 32'd1);

        // Training: remaining two taken pairs
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        #1 check("train_head2", 32'(head_pred), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        #1 check("train_head3", 32'(head_pred), 32'd1);
        cycle(1'b0, 1'b1, 1'b1);
        #1;
        check("train_branch_cnt", 32'(branch_cnt), 32'd3);
        check("train_mispredict_cnt", 32'(mispredict_cnt), 32'd2);

        // Full FIFO
        repeat (DEPTH) begin
            cycle(1'b1, 1'b0, 1'b0);
            idle_cycles(2);
        end
        #1;
        check("full_occupancy", 32'(occupancy), 32'(DEPTH));
        check("full_br_ready", 32'(br_ready), 32'd0);
        cycle(1'b0, 1'b1, 1'($urandom));
        #1 check("full_pop_occupancy", 32'(occupancy), 32'(DEPTH - 1));
        cycle(1'b0, 1'b0, 1'b0);
        #1 check("full_pop_br_ready", 32'(br_ready), 32'd1);

        // Collision at occupancy 1
        cycle(1'b0, 1'b1, 1'($urandom));
        cycle(1'b0, 1'b1, 1'($urandom));
        cycle(1'b1, 1'b1, 1'($urandom));
        #1;
        check("collision_occupancy", 32'(occupancy), 32'd0);
        check("collision_no_request", 32'(pred_request), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        #1 check("collision_late_request", 32'(pred_request), 32'd1);
        idle_cycles(2);

        // Reset during CAPTURE with two outstanding
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        #1 check("pre_reset_occupancy", 32'(occupancy), 32'd2);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        do_reset(2);
        cycle(1'b1, 1'b0, 1'b0);
        #1 check("post_reset_request", 32'(pred_request), 32'd1);
        idle_cycles(2);
        #1 check("post_reset_occupancy", 32'(occupancy), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 299) == 0) && !last_res_acc) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cycle(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0),
                      1'($urandom));
            end
        end

        // Drain
        for (int i = 0; i < 40 && (mq.size() > 0 || busy > 0); i++) begin
            cycle(1'b0, 1'b1, 1'($urandom));
        end
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
